// File: rtl/cache_miss_ctrl_if.sv
// rtl/cache_miss_ctrl_if.sv - access-stage, status, main-memory and array-command signals of the miss controller
// master is the controller side; slave is the cache datapath / memory side.
interface cache_miss_ctrl_if #(
    parameter int TAG_BITS = 14,
    parameter int IDX_BITS = 13
);
    logic                  pe_read;
    logic                  pe_write;
    logic                  pe_req_hit;
    logic [TAG_BITS-1:0]   pe_tag;
    logic [IDX_BITS-1:0]   pe_index;
    logic [3:0]            val_out;
    logic [3:0]            mod_out;
    logic [2:0]            lru;
    logic [4*TAG_BITS-1:0] tag_out_flat;
    logic                  mm_valid;

    logic                  pe_stall;
    logic [1:0]            fsm_victim_way;
    logic [31:0]           mm_a;
    logic                  mm_read;
    logic                  mm_write;
    logic                  fsm_cc_fill;
    logic                  fsm_cc_ary_write;
    logic [3:0]            fsm_cc_tag_write;
    logic [3:0]            fsm_bit_cmd;
    logic                  fsm_bit_cmd_valid;

    modport master (
        input  pe_read, pe_write, pe_req_hit, pe_tag, pe_index,
        input  val_out, mod_out, lru, tag_out_flat, mm_valid,
        output pe_stall, fsm_victim_way, mm_a, mm_read, mm_write,
        output fsm_cc_fill, fsm_cc_ary_write, fsm_cc_tag_write,
        output fsm_bit_cmd, fsm_bit_cmd_valid
    );

    modport slave (
        output pe_read, pe_write, pe_req_hit, pe_tag, pe_index,
        output val_out, mod_out, lru, tag_out_flat, mm_valid,
        input  pe_stall, fsm_victim_way, mm_a, mm_read, mm_write,
        input  fsm_cc_fill, fsm_cc_ary_write, fsm_cc_tag_write,
        input  fsm_bit_cmd, fsm_bit_cmd_valid
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// rtl/cache_miss_ctrl.sv - L1 miss controller: victim choice, write-back, line fill, array update and replay
// Memory command and address are registered from the next state so they are glitch-free flop outputs.
module cache_miss_ctrl #(
    parameter int TAG_BITS = 14,
    parameter int IDX_BITS = 13
) (
    input logic               clk,
    input logic               reset,
    cache_miss_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        FILL   = 3'd2,
        UPDATE = 3'd3,
        REPLAY = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          victim_q, victim_d;
    logic [TAG_BITS-1:0] req_tag_q, req_tag_d;
    logic [IDX_BITS-1:0] req_idx_q, req_idx_d;
    logic [TAG_BITS-1:0] wb_tag_q, wb_tag_d;
    logic [31:0]         mm_a_q, mm_a_d;
    logic                mm_read_q, mm_write_q;

    logic                pe_access;
    logic                miss;
    logic                start_miss;
    logic [1:0]          pick;
    logic                pick_dirty;
    logic [TAG_BITS-1:0] pick_tag;

    assign pe_access  = bus.pe_read | bus.pe_write;
    assign miss       = pe_access & ~bus.pe_req_hit;
    assign start_miss = (state_q == IDLE) && miss;

    // An invalid way always wins (lowest first); otherwise follow the pseudo-LRU tree.
    always_comb begin
        pick = bus.lru[0] ? {1'b1, bus.lru[2]} : {1'b0, bus.lru[1]};
        for (int n = 3; n >= 0; n--) begin
            if (!bus.val_out[n]) begin
                pick = 2'(n);
            end
        end
    end

    assign pick_dirty = bus.val_out[pick] & bus.mod_out[pick];
    assign pick_tag   = bus.tag_out_flat[int'(pick)*TAG_BITS +: TAG_BITS];

    assign req_tag_d = start_miss ? bus.pe_tag   : req_tag_q;
    assign req_idx_d = start_miss ? bus.pe_index : req_idx_q;
    assign wb_tag_d  = start_miss ? pick_tag     : wb_tag_q;

    always_comb begin
        state_d                = state_q;
        victim_d               = victim_q;
        bus.pe_stall           = 1'b0;
        bus.fsm_cc_fill        = 1'b0;
        bus.fsm_cc_ary_write   = 1'b0;
        bus.fsm_cc_tag_write   = 4'b0000;
        bus.fsm_bit_cmd        = 4'b0000;
        bus.fsm_bit_cmd_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.pe_stall = miss;
                if (pe_access && bus.pe_req_hit) begin
                    bus.fsm_bit_cmd_valid = 1'b1;
                    if (bus.pe_write) begin
                        bus.fsm_cc_ary_write = 1'b1;
                        bus.fsm_bit_cmd      = 4'd2;
                    end else begin
                        bus.fsm_bit_cmd      = 4'd1;
                    end
                end
                if (miss) begin
                    victim_d = pick;
                    state_d  = pick_dirty ? WB : FILL;
                end
            end
            WB: begin
                bus.pe_stall = 1'b1;
                if (bus.mm_valid) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                bus.pe_stall = 1'b1;
                if (bus.mm_valid) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                bus.pe_stall          = 1'b1;
                bus.fsm_cc_fill       = 1'b1;
                bus.fsm_cc_ary_write  = 1'b1;
                bus.fsm_cc_tag_write  = 4'b0001 << victim_q;
                bus.fsm_bit_cmd       = 4'd4;
                bus.fsm_bit_cmd_valid = 1'b1;
                state_d               = REPLAY;
            end
            REPLAY: begin
                // Arrays re-read the held address this cycle; the access then hits in IDLE.
                bus.pe_stall = 1'b1;
                victim_d     = 2'd0;
                state_d      = IDLE;
            end
            default: begin
                state_d  = IDLE;
                victim_d = 2'd0;
            end
        endcase
    end

    always_comb begin
        mm_a_d = 32'd0;
        unique case (state_d)
            WB:      mm_a_d = {wb_tag_d,  req_idx_d, 5'b00000};
            FILL:    mm_a_d = {req_tag_d, req_idx_d, 5'b00000};
            default: mm_a_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            victim_q   <= 2'd0;
            req_tag_q  <= '0;
            req_idx_q  <= '0;
            wb_tag_q   <= '0;
            mm_a_q     <= 32'd0;
            mm_read_q  <= 1'b0;
            mm_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            req_tag_q  <= req_tag_d;
            req_idx_q  <= req_idx_d;
            wb_tag_q   <= wb_tag_d;
            mm_a_q     <= mm_a_d;
            mm_read_q  <= (state_d == FILL);
            mm_write_q <= (state_d == WB);
        end
    end

    assign bus.mm_a           = mm_a_q;
    assign bus.mm_read        = mm_read_q;
    assign bus.mm_write       = mm_write_q;
    assign bus.fsm_victim_way = victim_q;
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb/tb_cache_miss_ctrl.sv - directed bench for cache_miss_ctrl with a queue-based reference model
module tb_cache_miss_ctrl;
    localparam int TB = 14;
    localparam int IB = 13;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_miss_ctrl_if #(.TAG_BITS(TB), .IDX_BITS(IB)) bus ();
    cache_miss_ctrl #(.TAG_BITS(TB), .IDX_BITS(IB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   total = 0;
    int   bad   = 0;
    logic checking = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pending memory operations as a queue, then a two-cycle tail (update, replay).
    typedef struct {
        logic        wr;
        logic [31:0] a;
    } op_t;
    op_t        ops[$];
    int         post = 0;
    logic [1:0] mv   = 2'd0;

    function automatic logic [1:0] victim_of(input logic [3:0] val, input logic [2:0] lru);
        for (int n = 0; n < 4; n++) begin
            if (!val[n]) return 2'(n);
        end
        return lru[0] ? 2'(2 + int'(lru[2])) : 2'(int'(lru[1]));
    endfunction

    always @(negedge clk) begin
        logic        acc, hit, e_stall, e_rd, e_wr, e_fill, e_aw, e_bv;
        logic [1:0]  e_v;
        logic [3:0]  e_tw, e_bc;
        logic [31:0] e_a;
        op_t         op;
        acc = bus.pe_read | bus.pe_write;
        hit = bus.pe_req_hit;
        e_stall = 0; e_rd = 0; e_wr = 0; e_fill = 0; e_aw = 0; e_bv = 0;
        e_v = 0; e_tw = 0; e_bc = 0; e_a = 0;
        if (ops.size() > 0) begin
            e_stall = 1; e_v = mv; e_a = ops[0].a; e_wr = ops[0].wr; e_rd = !ops[0].wr;
        end else if (post == 2) begin
            e_stall = 1; e_v = mv; e_fill = 1; e_aw = 1; e_tw = 4'b0001 << mv; e_bc = 4; e_bv = 1;
        end else if (post == 1) begin
            e_stall = 1; e_v = mv;
        end else begin
            e_stall = acc & !hit;
            if (acc && hit) begin
                e_bv = 1;
                if (bus.pe_write) begin e_aw = 1; e_bc = 2; end
                else e_bc = 1;
            end
        end
        if (checking) begin
            check("model", {bus.pe_stall, bus.fsm_victim_way, bus.mm_a, bus.mm_read, bus.mm_write,
                            bus.fsm_cc_fill, bus.fsm_cc_ary_write, bus.fsm_cc_tag_write,
                            bus.fsm_bit_cmd, bus.fsm_bit_cmd_valid},
                           {e_stall, e_v, e_a, e_rd, e_wr, e_fill, e_aw, e_tw, e_bc, e_bv});
            check("rd_wr_overlap", bus.mm_read & bus.mm_write, 0);
        end
        if (reset) begin
            ops.delete(); post = 0; mv = 0;
        end else if (ops.size() > 0) begin
            if (bus.mm_valid) begin
                op = ops.pop_front();
                if (ops.size() == 0) post = 2;
            end
        end else if (post > 0) begin
            post--;
        end else if (acc && !hit) begin
            mv = victim_of(bus.val_out, bus.lru);
            if (bus.val_out[mv] && bus.mod_out[mv]) begin
                op.wr = 1; op.a = {bus.tag_out_flat[int'(mv)*TB +: TB], bus.pe_index, 5'b00000};
                ops.push_back(op);
            end
            op.wr = 0; op.a = {bus.pe_tag, bus.pe_index, 5'b00000};
            ops.push_back(op);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pe_read = 0; bus.pe_write = 0; bus.pe_req_hit = 0;
        bus.pe_tag = '0; bus.pe_index = '0; bus.val_out = 4'hF; bus.mod_out = 0;
        bus.lru = 0; bus.tag_out_flat = {14'h0033, 14'h2AAA, 14'h0022, 14'h0011}; bus.mm_valid = 0;
    endtask

    task automatic do_miss(input string nm, input logic wr, input logic [13:0] tag, input logic [12:0] idx,
                           input logic [3:0] val, input logic [3:0] mod, input logic [2:0] lru,
                           input int wb_lat, input int rd_lat, input logic [1:0] exp_v,
                           input logic exp_dirty, input logic [31:0] exp_wba, input logic [31:0] exp_rda,
                           input int exp_stall);
        int   stall_n = 0, rdc = 0, wbc = 0;
        logic upd_seen = 0, done = 0;
        tick();
        bus.pe_read = !wr; bus.pe_write = wr; bus.pe_req_hit = 0;
        bus.pe_tag = tag; bus.pe_index = idx; bus.val_out = val; bus.mod_out = mod; bus.lru = lru;
        #1;
        check({nm, "_stall0"}, bus.pe_stall, 1);
        stall_n = 1;
        for (int c = 1; c < 60 && !done; c++) begin
            tick();
            if (upd_seen) bus.pe_req_hit = 1;
            if (bus.mm_write) wbc++;
            if (bus.mm_read) rdc++;
            if (bus.mm_write && wbc == 1) check({nm, "_wb_addr"}, bus.mm_a, exp_wba);
            if (bus.mm_read && rdc == 1) begin
                check({nm, "_rd_addr"}, bus.mm_a, exp_rda);
                check({nm, "_wb_before_rd"}, wbc, exp_dirty ? wb_lat : 0);
            end
            bus.mm_valid = (bus.mm_write && wbc == wb_lat) || (bus.mm_read && rdc == rd_lat);
            #1;
            if (bus.fsm_cc_fill) begin
                check({nm, "_update"}, {bus.fsm_victim_way, bus.fsm_cc_tag_write, bus.fsm_bit_cmd,
                                        bus.fsm_bit_cmd_valid, bus.fsm_cc_ary_write},
                                       {exp_v, 4'b0001 << exp_v, 4'd4, 1'b1, 1'b1});
                upd_seen = 1;
            end
            if (bus.pe_stall) stall_n++;
            else begin
                done = 1;
                check({nm, "_hit_cmd"}, {bus.fsm_bit_cmd_valid, bus.fsm_bit_cmd, bus.fsm_cc_ary_write},
                                        {1'b1, wr ? 4'd2 : 4'd1, wr});
            end
        end
        check({nm, "_stall_cycles"}, stall_n, exp_stall);
        tick();
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        tick();
        checking = 1;
        tick();
        reset = 0;
        #1;
        check("reset_outputs", {bus.pe_stall, bus.fsm_victim_way, bus.mm_a, bus.mm_read, bus.mm_write,
                                bus.fsm_cc_fill, bus.fsm_cc_ary_write, bus.fsm_cc_tag_write,
                                bus.fsm_bit_cmd, bus.fsm_bit_cmd_valid}, 0);

        tick(); bus.mm_valid = 1; #1;
        check("idle_ack_no_write", bus.fsm_cc_ary_write, 0);
        tick(); bus.mm_valid = 0; #1;
        check("idle_ack_no_read", {bus.mm_read, bus.pe_stall}, 0);

        tick(); bus.pe_read = 1; bus.pe_req_hit = 1; #1;
        check("read_hit", {bus.fsm_bit_cmd_valid, bus.fsm_bit_cmd, bus.pe_stall, bus.fsm_cc_ary_write},
                          {1'b1, 4'd1, 1'b0, 1'b0});
        tick(); bus.pe_read = 0; bus.pe_write = 1; #1;
        check("write_hit", {bus.fsm_bit_cmd_valid, bus.fsm_bit_cmd, bus.pe_stall, bus.fsm_cc_ary_write},
                           {1'b1, 4'd2, 1'b0, 1'b1});
        tick(); idle_inputs();

        // Reset while a fill is outstanding.
        tick(); bus.pe_read = 1; bus.pe_tag = 14'h0155; bus.pe_index = 13'h0042; bus.val_out = 4'b0000;
        tick(); #1;
        check("rst_fill_active", bus.mm_read, 1);
        reset = 1;
        tick(); reset = 0; bus.pe_read = 0; #1;
        check("rst_idle", {bus.mm_read, bus.mm_write, bus.pe_stall}, 0);
        tick(); bus.mm_valid = 1; #1;
        check("rst_late_ack", {bus.fsm_cc_ary_write, bus.fsm_cc_fill}, 0);
        tick(); bus.mm_valid = 0; #1;
        check("rst_late_ack2", {bus.fsm_cc_ary_write, bus.fsm_cc_tag_write, bus.mm_read}, 0);
        idle_inputs();

        do_miss("clean", 0, 14'h1234, 13'h00A5, 4'b0111, 4'b0000, 3'b000, 0, 3, 2'd3, 0,
                32'h0, 32'h48D0_14A0, 6);
        do_miss("dirty", 1, 14'h0777, 13'h01F0, 4'b1111, 4'b0100, 3'b001, 2, 1, 2'd2, 1,
                32'hAAA8_3E00, 32'h1DDC_3E00, 6);
        do_miss("lru000", 0, 14'h0001, 13'h0003, 4'b1111, 4'b0000, 3'b000, 0, 1, 2'd0, 0,
                32'h0, 32'h0004_0060, 4);
        do_miss("lru110", 1, 14'h0001, 13'h0003, 4'b1111, 4'b0000, 3'b110, 0, 1, 2'd1, 0,
                32'h0, 32'h0004_0060, 4);
        do_miss("lru101", 0, 14'h0002, 13'h0001, 4'b1111, 4'b0000, 3'b101, 0, 2, 2'd3, 0,
                32'h0, 32'h0008_0020, 5);

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Miss-handling controller for the 1MB 4-way 32B-line L1 cache. It observes the registered access stage (hit/miss, valid/dirty bits, LRU, tags) and chooses a victim way on a miss. It sequences dirty-line write-back and line fill against main memory, then replays the access. It drives the cache array write, tag write and status-bit commands, and stalls the requester while a miss is outstanding.

## Interface
- TAG_BITS, 14, tag width (a[31:18])
- IDX_BITS, 13, set index width (a[17:5])
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pe_read, pe_write  in  1  registered access stage; both high is treated as a write
- pe_req_hit  in  1  registered access hit (valid & tag match)
- pe_tag  in  TAG_BITS  registered request tag
- pe_index  in  IDX_BITS  registered request index
- val_out, mod_out  in  4  valid/dirty bits of the indexed set
- lru  in  3  pseudo-LRU tree bits of the indexed set
- tag_out_flat  in  4*TAG_BITS  way n tag at [n*TAG_BITS +: TAG_BITS]
- mm_valid  in  1  one-cycle pulse acknowledging the current mm_read (fill data on mm_rd) or mm_write
- pe_stall  out  1  requester must hold a/be/read/write/wd
- fsm_victim_way  out  2  way selected for eviction/fill; selects mm_wd data mux
- mm_a  out  32  line address, bits [4:0] = 0
- mm_read, mm_write  out  1  level commands to main memory
- fsm_cc_fill  out  1  selects mm_rd / all-ones byte enables into the data arrays
- fsm_cc_ary_write  out  1  data array write strobe
- fsm_cc_tag_write  out  4  one-hot tag write strobe
- fsm_bit_cmd  out  4  status-bit command; 1=TOUCH (LRU), 2=WRHIT (set mod + LRU), 4=FILL (set val, clear mod, LRU for fsm_victim_way)
- fsm_bit_cmd_valid  out  1  fsm_bit_cmd qualifier

## Operation
- States: IDLE, WB, FILL, UPDATE, REPLAY.
- pe_access = pe_read | pe_write.
- IDLE, hit read: fsm_bit_cmd=1 with valid, combinational.
- IDLE, hit write: fsm_cc_ary_write=1 and fsm_bit_cmd=2 with valid, combinational. The datapath gates the write with way_hit.
- IDLE, miss (pe_access & !pe_req_hit):
  - pe_stall=1 combinationally.
  - Latch pe_tag and pe_index.
  - Latch the victim: the lowest-numbered way with val_out=0. If all ways are valid: lru[0]=0 selects way lru[1] (0 or 1); lru[0]=1 selects way 2+lru[2].
  - Go to WB if the victim is valid and dirty, else go to FILL.
- WB:
  - mm_write=1, mm_a={victim tag, latched index, 5'b0}.
  - Hold until mm_valid, then go to FILL.
- FILL:
  - mm_read=1, mm_a={latched tag, latched index, 5'b0}.
  - Hold until mm_valid, then go to UPDATE.
- UPDATE (1 cycle):
  - fsm_cc_fill=1, fsm_cc_ary_write=1.
  - fsm_cc_tag_write=onehot(victim).
  - fsm_bit_cmd=4 with valid.
  - Go to REPLAY.
- REPLAY (1 cycle): no strobes. The arrays re-read the held address after the write. Go to IDLE, where the held access hits and is processed as a normal hit.
- pe_stall=1 in WB, FILL, UPDATE and REPLAY.
- fsm_victim_way is stable from WB entry until REPLAY exit.
- mm_read and mm_write are never both high.
- mm_valid is ignored in IDLE, UPDATE and REPLAY.

## Timing
- Reset, and every output in IDLE with no access: all outputs 0, state IDLE, fsm_victim_way=0.
- Reset asserted in any state goes to IDLE on the next edge. The outstanding memory command drops, and any later mm_valid is ignored.
- Clean miss detected in cycle 0:
  - FILL runs from cycle 1; mm_valid arrives in cycle k≥1 (same-cycle ack allowed).
  - UPDATE is cycle k+1, REPLAY is k+2, hit is k+3.
  - pe_stall is high in cycles 0..k+2 and low in cycle k+3.
- Dirty miss: WB precedes FILL, adding (write-ack latency) cycles.
- mm_a, mm_read and mm_write are registered (state-decoded from flops).
- pe_stall in IDLE and the IDLE hit strobes are combinational from the access stage.
- Every transition takes exactly one state per edge; no state is skipped even if mm_valid is already high on entry.

## Test plan
- Reset: assert reset mid-FILL for 1 cycle → next cycle IDLE, mm_read=0, pe_stall=0; a subsequent mm_valid pulse causes no array write.
- Clean miss, set 0x0A5, val_out=4'b0111, mm_valid 3 cycles after mm_read:
  - victim=3, mm_a={pe_tag,13'h0A5,5'b0}.
  - UPDATE drives fsm_cc_tag_write=4'b1000, fsm_bit_cmd=4.
  - pe_stall is high exactly 6 cycles.
- Dirty miss: all valid, mod_out=4'b0100, lru=3'b001 → victim 2.
  - mm_write first with mm_a={tag_out way2, index, 5'b0}.
  - After its mm_valid, mm_read with the request tag.
- All valid, lru=3'b000 → victim 0; lru=3'b110 → victim 1; lru=3'b101 → victim 3.
- Write hit: fsm_cc_ary_write=1, fsm_bit_cmd=2 with valid in the same cycle, pe_stall=0.
- Write miss: after fill and replay, the IDLE hit cycle issues fsm_bit_cmd=2.
- Protocol checks: mm_read and mm_write never overlap; mm_valid in IDLE is ignored.
